// File: rtl/vlw_pack.sv
// vlw_pack: serial-to-parallel packer feeding the adder-tree VLW input.
// Collects VLW_LEN words from a valid/ready stream into one vector. The first
// accepted word lands in the MSB lane, the last one in the LSB lane.
// Double-buffered: a fill register collects lanes while the output register
// holds a completed vector for the consumer, so one word per cycle is
// sustained while downstream accepts.
// Optional build macro VLW_PACK_FLUSH_EN adds the in_last port. A word
// accepted with in_last=1 closes the vector early, and the unwritten lanes
// are zero so a downstream sum is unaffected.
module vlw_pack #(
    parameter int WORD_WDT = 16,
    parameter int VLW_LEN  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clk_en,
    input  logic [WORD_WDT-1:0]          in_word,
    input  logic                         in_word_val,
    output logic                         in_word_rdy,
`ifdef VLW_PACK_FLUSH_EN
    input  logic                         in_last,
`endif
    output logic [WORD_WDT*VLW_LEN-1:0]  out_vlw,
    output logic                         out_vlw_val,
    input  logic                         out_vlw_rdy
);

    localparam int CNT_WDT = $clog2(VLW_LEN);
    localparam int VEC_WDT = WORD_WDT * VLW_LEN;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]          state_q,    state_d;
    logic [CNT_WDT-1:0]  lane_cnt_q, lane_cnt_d;
    logic [VEC_WDT-1:0]  fill_q,     fill_d;
    logic [VEC_WDT-1:0]  out_vlw_q,  out_vlw_d;
    logic                out_val_q,  out_val_d;

    logic                accept_s;
    logic                emit_s;
    logic                last_s;
    logic [CNT_WDT-1:0]  wr_lane_s;
    logic [VEC_WDT-1:0]  cur_vec_s;

    // Handshake qualifiers; ready depends on state only so it never loops
    // back through the consumer's ready or the producer's valid.
    always_comb begin
        in_word_rdy = (state_q == ST_FILL);
        accept_s    = in_word_val & in_word_rdy & clk_en;
        emit_s      = out_val_q & out_vlw_rdy & clk_en;
        wr_lane_s   = CNT_WDT'(VLW_LEN - 1) - lane_cnt_q;
`ifdef VLW_PACK_FLUSH_EN
        last_s      = (lane_cnt_q == CNT_WDT'(VLW_LEN - 1)) | in_last;
`else
        last_s      = (lane_cnt_q == CNT_WDT'(VLW_LEN - 1));
`endif
    end

    // Fill register with the incoming word merged into its lane; lane index
    // counts down from the MSB lane as lane_cnt counts up.
    always_comb begin
        cur_vec_s = fill_q;
        for (int i = 0; i < VLW_LEN; i++) begin
            if (CNT_WDT'(i) == wr_lane_s) begin
                cur_vec_s[i*WORD_WDT +: WORD_WDT] = in_word;
            end else begin
                cur_vec_s[i*WORD_WDT +: WORD_WDT] = fill_q[i*WORD_WDT +: WORD_WDT];
            end
        end
    end

    // Next-state logic. The fill register is cleared whenever its content
    // moves to the output slot, so every new vector starts from all-zero lanes.
    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        fill_d     = fill_q;
        out_vlw_d  = out_vlw_q;
        out_val_d  = out_val_q;

        case (state_q)
            ST_FILL: begin
                // A drained slot goes empty unless a new vector loads below.
                if (emit_s) begin
                    out_val_d = 1'b0;
                end else begin
                    out_val_d = out_val_q;
                end

                if (accept_s) begin
                    if (last_s) begin
                        lane_cnt_d = {CNT_WDT{1'b0}};
                        if (!out_val_q || emit_s) begin
                            out_vlw_d = cur_vec_s;
                            out_val_d = 1'b1;
                            fill_d    = {VEC_WDT{1'b0}};
                        end else begin
                            fill_d  = cur_vec_s;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        lane_cnt_d = lane_cnt_q + CNT_WDT'(1);
                        fill_d     = cur_vec_s;
                    end
                end else begin
                    lane_cnt_d = lane_cnt_q;
                end
            end

            ST_HOLD: begin
                // Completed vector parked in the fill register until the
                // output slot drains; then it moves over with no bubble.
                if (emit_s) begin
                    out_vlw_d = fill_q;
                    out_val_d = 1'b1;
                    fill_d    = {VEC_WDT{1'b0}};
                    state_d   = ST_FILL;
                end else begin
                    state_d   = ST_HOLD;
                end
            end

            default: begin
                state_d    = ST_FILL;
                lane_cnt_d = {CNT_WDT{1'b0}};
                fill_d     = {VEC_WDT{1'b0}};
            end
        endcase
    end

    // State registers; asynchronous reset discards any partial vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            lane_cnt_q <= {CNT_WDT{1'b0}};
            fill_q     <= {VEC_WDT{1'b0}};
            out_vlw_q  <= {VEC_WDT{1'b0}};
            out_val_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            fill_q     <= fill_d;
            out_vlw_q  <= out_vlw_d;
            out_val_q  <= out_val_d;
        end
    end

    // Output vector and valid come straight from flops.
    always_comb begin
        out_vlw     = out_vlw_q;
        out_vlw_val = out_val_q;
    end

endmodule

// File: tb/tb_vlw_pack.sv
// Testbench for vlw_pack. A queue-based model tracks accepted words and
// completed vectors, and every cycle the DUT handshake and vector outputs
// are compared against that model. Directed sequences add literal
// expectations for the vector contents and timing.
module tb_vlw_pack;

    localparam int W  = 16;
    localparam int L  = 8;
    localparam int VW = W * L;

    logic          clk;
    logic          rst_n;
    logic          clk_en;
    logic [W-1:0]  in_word;
    logic          in_word_val;
    logic          in_word_rdy;
`ifdef VLW_PACK_FLUSH_EN
    logic          in_last;
`endif
    logic [VW-1:0] out_vlw;
    logic          out_vlw_val;
    logic          out_vlw_rdy;

    int tests_run;
    int tests_failed;
    int cyc;

    vlw_pack #(.WORD_WDT(W), .VLW_LEN(L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .in_word     (in_word),
        .in_word_val (in_word_val),
        .in_word_rdy (in_word_rdy),
`ifdef VLW_PACK_FLUSH_EN
        .in_last     (in_last),
`endif
        .out_vlw     (out_vlw),
        .out_vlw_val (out_vlw_val),
        .out_vlw_rdy (out_vlw_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // part: words of the vector being collected, oldest first.
    // vecs: completed vectors not yet taken by the consumer (at most two:
    // one in the output slot and one parked behind it).
    logic [W-1:0]  part[$];
    logic [VW-1:0] vecs[$];
    logic          m_acc, m_emit, m_last;
    logic [VW-1:0] m_vec;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part.delete();
            vecs.delete();
        end else begin
            m_acc  = in_word_val && (vecs.size() < 2) && clk_en;
            m_emit = (vecs.size() > 0) && out_vlw_rdy && clk_en;
`ifdef VLW_PACK_FLUSH_EN
            m_last = in_last;
`else
            m_last = 1'b0;
`endif
            if (m_emit) void'(vecs.pop_front());
            if (m_acc) begin
                part.push_back(in_word);
                if (part.size() == L || m_last) begin
                    m_vec = '0;
                    foreach (part[k]) m_vec = m_vec | (VW'(part[k]) << ((L - 1 - k) * W));
                    vecs.push_back(m_vec);
                    part.delete();
                end
            end
        end
    end

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("val", VW'(out_vlw_val), VW'(vecs.size() > 0));
            check("rdy", VW'(in_word_rdy), VW'(vecs.size() < 2));
            if (vecs.size() > 0) check("vec", out_vlw, vecs[0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic feed(input logic [W-1:0] w);
        @(negedge clk);
        in_word     = w;
        in_word_val = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_word_val = 1'b0;
    endtask

    int t_val[3];
    int n_val;
    int n_rdy_low;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        rst_n        = 1'b0;
        clk_en       = 1'b1;
        in_word      = '0;
        in_word_val  = 1'b0;
        out_vlw_rdy  = 1'b1;
`ifdef VLW_PACK_FLUSH_EN
        in_last      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_val", VW'(out_vlw_val), VW'(0));
        check("rst_vec", out_vlw, VW'(0));
        rst_n = 1'b1;

        // 1: one full vector, slot free
        for (int i = 1; i <= 8; i++) begin
            feed(W'(i));
            check("t1_rdy", VW'(in_word_rdy), VW'(1));
        end
        idle();
        check("t1_val", VW'(out_vlw_val), VW'(1));
        check("t1_vec", out_vlw, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
        idle();
        check("t1_drain", VW'(out_vlw_val), VW'(0));

        // 2: 24 words back to back
        n_val = 0;
        n_rdy_low = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < 24) feed(W'(16'h0100 + i));
            else idle();
            if (out_vlw_val) begin
                if (n_val < 3) t_val[n_val] = cyc;
                n_val++;
            end
            if (!in_word_rdy) n_rdy_low++;
        end
        check("t2_count", VW'(n_val), VW'(3));
        check("t2_gap01", VW'(t_val[1] - t_val[0]), VW'(8));
        check("t2_gap12", VW'(t_val[2] - t_val[1]), VW'(8));
        check("t2_rdylow", VW'(n_rdy_low), VW'(0));

        // 3: consumer stalled for two vectors
        out_vlw_rdy = 1'b0;
        for (int i = 1; i <= 8; i++) feed(W'(16'h0010 + i));
        for (int i = 1; i <= 8; i++) feed(W'(16'h0020 + i));
        idle();
        check("t3_hold_rdy", VW'(in_word_rdy), VW'(0));
        check("t3_hold_vec", out_vlw, 128'h0011_0012_0013_0014_0015_0016_0017_0018);
        idle();
        check("t3_stable", out_vlw, 128'h0011_0012_0013_0014_0015_0016_0017_0018);
        out_vlw_rdy = 1'b1;
        idle();
        check("t3_second", out_vlw, 128'h0021_0022_0023_0024_0025_0026_0027_0028);
        check("t3_val", VW'(out_vlw_val), VW'(1));
        check("t3_rdy_back", VW'(in_word_rdy), VW'(1));
        idle();
        check("t3_drain", VW'(out_vlw_val), VW'(0));

        // 4: clock enable low mid-vector
        for (int i = 1; i <= 3; i++) feed(W'(16'h0040 + i));
        for (int i = 0; i < 5; i++) begin
            feed(16'hDEAD);
            clk_en = 1'b0;
        end
        check("t4_lane_cnt", VW'(dut.lane_cnt_q), VW'(3));
        for (int i = 4; i <= 8; i++) begin
            feed(W'(16'h0040 + i));
            clk_en = 1'b1;
        end
        idle();
        check("t4_vec", out_vlw, 128'h0041_0042_0043_0044_0045_0046_0047_0048);

        // 5: asynchronous reset mid-vector
        for (int i = 1; i <= 5; i++) feed(W'(16'h0050 + i));
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_val", VW'(out_vlw_val), VW'(0));
        check("t5_rst_vec", out_vlw, VW'(0));
        check("t5_rst_cnt", VW'(dut.lane_cnt_q), VW'(0));
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) feed(W'(16'h0060 + i));
        idle();
        check("t5_vec", out_vlw, 128'h0061_0062_0063_0064_0065_0066_0067_0068);

`ifdef VLW_PACK_FLUSH_EN
        // 6: early close with zero-filled tail lanes
        feed(16'h000A);
        feed(16'h000B);
        feed(16'h000C);
        in_last = 1'b1;
        idle();
        in_last = 1'b0;
        check("t6_flush", out_vlw, 128'h000A_000B_000C_0000_0000_0000_0000_0000);
        for (int i = 1; i <= 8; i++) feed(W'(16'h0070 + i));
        idle();
        check("t6_next", out_vlw, 128'h0071_0072_0073_0074_0075_0076_0077_0078);
`endif

        repeat (3) idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
